// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state type for the register-file access arbiter.
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int DEPTH_DEF  = 32;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;
endpackage

// File: rtl/regfile_access_arb_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational from req and the pointer.
// Latency 0 for grant; the pointer moves on advance to the requester that lost.
// Backpressure: a requester without grant simply keeps req high and is served next.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   logic ptr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else if (advance) begin
         // Winner 0 hands priority to 1, winner 1 hands it back to 0.
         ptr_q <= gnt[0];
      end
   end

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr_q ? 2'b10 : 2'b01;
      end
   end
endmodule

// File: rtl/regfile_access_arb.sv
// Arbitrates two write requesters onto one register-file write port and registers two read ports.
// Latency 1 for writes and reads; optional post-reset zero sweep under REGFILE_CLEAR_EN.
// Backpressure: wr*_ready is withheld during reset and the sweep, and from the losing requester.
module regfile_access_arb
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr0_valid,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   output logic              wr0_ready,
   input  logic              wr1_valid,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   output logic              wr1_ready,
   input  logic              rd0_en,
   input  logic [ADDR_W-1:0] rd0_addr,
   input  logic              rd1_en,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [ADDR_W-1:0] address_w,
   output logic              enable_w,
   output logic [DATA_W-1:0] In,
   output logic [ADDR_W-1:0] address_a,
   output logic              enable_a,
   output logic [ADDR_W-1:0] address_b,
   output logic              enable_b,
   output logic              init_done
);
   logic              run;
   logic              clr_wr;
   logic [ADDR_W-1:0] clr_addr;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              xfer;

`ifdef REGFILE_CLEAR_EN
   // One extra counter bit so the sweep can count past the last address.
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] SWEEP_END = CNT_W'(DEPTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] sweep_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         if (clr_wr) begin
            sweep_q <= sweep_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      clr_wr  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            if (sweep_q == SWEEP_END) begin
               state_d = ST_RUN;
            end else begin
               clr_wr = 1'b1;
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_CLEAR;
      endcase
   end

   assign clr_addr = sweep_q[ADDR_W-1:0];
   assign run      = (state_q == ST_RUN);
`else
   state_t state_q;

   assign state_q  = ST_RUN;
   assign run      = (state_q == ST_RUN);
   assign clr_wr   = 1'b0;
   // No sweep in this build; the address mux leg is never selected.
   assign clr_addr = ADDR_W'(DEPTH - 1);
`endif

   assign init_done = run;

   // Reset masks requests so a grant can never be issued and then lost.
   assign req       = {wr1_valid, wr0_valid} & {2{run & ~rst}};
   assign wr0_ready = gnt[0];
   assign wr1_ready = gnt[1];
   assign xfer      = |gnt;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (xfer),
      .gnt     (gnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         enable_w  <= 1'b0;
         address_w <= '0;
         In        <= '0;
         enable_a  <= 1'b0;
         address_a <= '0;
         enable_b  <= 1'b0;
         address_b <= '0;
      end else begin
         if (clr_wr) begin
            enable_w  <= 1'b1;
            address_w <= clr_addr;
            In        <= '0;
         end else begin
            enable_w <= xfer;
            if (xfer) begin
               address_w <= gnt[1] ? wr1_addr : wr0_addr;
               In        <= gnt[1] ? wr1_data : wr0_data;
            end
         end
         enable_a <= run & rd0_en;
         enable_b <= run & rd1_en;
         if (run) begin
            address_a <= rd0_addr;
            address_b <= rd1_addr;
         end
      end
   end
endmodule

// File: doc/regfile_access_arb.md
REGFILE_ACCESS_ARB -- requirements
Module: regfile_access_arb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width.
REQ-003 Parameter DEPTH, default 32, SHALL set the register count swept by clear.
REQ-004 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr0_valid / wr1_valid  in  1  requester 0/1 write request
- wr0_addr / wr1_addr  in  ADDR_W  write address
- wr0_data / wr1_data  in  DATA_W  write data
- wr0_ready / wr1_ready  out  1  write grant; transfer when valid && ready
- rd0_en / rd1_en  in  1  read request, requester 0 to port A, requester 1 to port B
- rd0_addr / rd1_addr  in  ADDR_W  read address
- address_w  out  ADDR_W  register-file write address
- enable_w  out  1  register-file write enable
- In  out  DATA_W  register-file write data
- address_a, enable_a  out  ADDR_W, 1  register-file read port A
- address_b, enable_b  out  ADDR_W, 1  register-file read port B
- init_done  out  1  high once the clear sweep is complete

Function
REQ-005 FSM states SHALL be CLEAR and RUN; CLEAR -> RUN after the write to address DEPTH-1; RUN is terminal until rst.
REQ-006 In CLEAR: enable_w=1, In=0, address_w steps 0..DEPTH-1, one per cycle; wr*_ready=0; enable_a/enable_b=0.
REQ-007 In RUN, the write port SHALL be arbitrated round-robin between requesters with a 1-bit priority pointer.
REQ-008 Only one valid: that requester gets ready in the same cycle (combinational from valid, state, pointer).
REQ-009 Both valid: the pointer's requester gets ready; the other's ready stays 0.
REQ-010 After every transfer the pointer SHALL point to the non-granted requester.
REQ-011 A transfer SHALL drive address_w/In/enable_w=1 on the next cycle (latency 1); no transfer -> enable_w=0, address_w/In hold.
REQ-012 Requesters SHALL hold valid, addr and data stable until ready; the block does not drop a pending request.
REQ-013 In RUN, address_a/enable_a SHALL register rd0_addr/rd0_en and address_b/enable_b SHALL register rd1_addr/rd1_en (latency 1, same as writes).
REQ-014 init_done SHALL rise on the first RUN cycle and stay high.
REQ-015 Read and write to the same address in one cycle are both forwarded; ordering is resolved by the register file.

Reset
REQ-016 rst SHALL set enable_w=0, address_w=0, In=0, enable_a=enable_b=0, address_a=address_b=0, pointer=0, wr*_ready=0.
REQ-017 rst SHALL enter CLEAR with sweep address 0 and init_done=0; rst mid-sweep restarts the sweep at 0.
REQ-018 rst during RUN SHALL drop any granted-not-issued write.

Configuration
REQ-019 Macro REGFILE_CLEAR_EN defined: CLEAR is implemented as above.
REQ-020 Macro REGFILE_CLEAR_EN undefined: no CLEAR state, reset enters RUN, init_done resets to 1, arbitration starts the first cycle after rst.

Structure
REQ-021 Package regfile_pkg SHALL hold DATA_W/ADDR_W/DEPTH defaults and the state enum type.
REQ-022 Round-robin logic SHALL be sub-module rr_arb2 (req[1:0], advance, gnt[1:0], registered pointer).

Verification
REQ-023 rst 1 cycle, macro on -> 32 cycles enable_w=1, In=0, address_w 0..31; init_done=1 on cycle 33; ready=0 throughout.
REQ-024 RUN, wr0 only valid addr=5 data=0xDEADBEEF -> wr0_ready same cycle; next cycle address_w=5, In=0xDEADBEEF, enable_w=1.
REQ-025 Both valid 4 cycles, pointer=0 -> grants 0,1,0,1; enable_w=1 on cycles 2-5 with alternating addresses.
REQ-026 rst asserted at sweep address 10 -> next sweep write at address 0; init_done stays 0 until 32 clears complete.
REQ-027 rd0_en=1 addr=3, rd1_en=1 addr=17 in RUN -> next cycle enable_a=1 address_a=3, enable_b=1 address_b=17; during CLEAR both enables stay 0.
REQ-028 Macro off, rst released -> init_done=1, wr1_valid addr=31 granted first cycle.
